// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings and mul/div engine states shared by the execute stage
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SLL    = 6'h00;
  localparam logic [5:0] F_SRL    = 6'h02;
  localparam logic [5:0] F_SRA    = 6'h03;
  localparam logic [5:0] F_MFHI   = 6'h10;
  localparam logic [5:0] F_MFLO   = 6'h12;
  localparam logic [5:0] F_MULT   = 6'h18;
  localparam logic [5:0] F_MULTU  = 6'h19;
  localparam logic [5:0] F_DIV    = 6'h1A;
  localparam logic [5:0] F_DIVU   = 6'h1B;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_SUBU   = 6'h23;
  localparam logic [5:0] F_AND    = 6'h24;
  localparam logic [5:0] F_OR     = 6'h25;
  localparam logic [5:0] F_XOR    = 6'h26;
  localparam logic [5:0] F_NOR    = 6'h27;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam logic [5:0] F_SLTU   = 6'h2B;
  typedef enum logic [1:0] {IDLE, MUL, DIV} md_state_t;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiply / restoring divide on magnitudes, owns HI/LO
module muldiv_unit import mips_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(MD_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);
  md_state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] p, p_step, prod;
  logic [WIDTH-1:0] mag_b, rs_q, a_mag, b_mag, q, r, hi_next, div_diff;
  logic [WIDTH:0] mul_sum, div_sh;
  logic neg_q, neg_r, div_ge;
  assign a_mag = (is_signed & a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed & b[WIDTH-1]) ? -b : b;
  assign busy = state != IDLE;
  assign done = busy && cnt == LAST;
  // p holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mag_b} : '0);
    div_sh = p[2*WIDTH-1:WIDTH-1];
    div_ge = div_sh >= {1'b0, mag_b};
    div_diff = div_sh[WIDTH-1:0] - mag_b;
    p_step = state == DIV ? {div_ge ? div_diff : div_sh[WIDTH-1:0], p[WIDTH-2:0], div_ge}
                          : {mul_sum, p[WIDTH-1:1]};
    prod = neg_q ? -p_step : p_step;
    q = p_step[WIDTH-1:0];
    r = p_step[2*WIDTH-1:WIDTH];
    hi_next = state == DIV ? (mag_b == '0 ? rs_q : neg_r ? -r : r) : prod[2*WIDTH-1:WIDTH];
    lo_next = state == DIV ? (mag_b == '0 ? '1 : neg_q ? -q : q) : prod[WIDTH-1:0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      p <= '0;
      mag_b <= '0;
      rs_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (start && !busy) begin
      state <= is_div ? DIV : MUL;
      cnt <= '0;
      p <= {{WIDTH{1'b0}}, a_mag};
      mag_b <= b_mag;
      rs_q <= a;
      neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= is_signed & a[WIDTH-1];
    end else if (busy) begin
      p <= p_step;
      cnt <= cnt + 1'b1;
      if (done) begin
        state <= IDLE;
        hi <= hi_next;
        lo <= lo_next;
      end
    end
  end
endmodule

// File: rtl/alu_execute.sv
// alu_execute: MIPS execute stage ALU with handshake; ALU_MULDIV_EN adds HI/LO and the mul/div engine
module alu_execute import mips_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic [WIDTH-1:0] imm_ext,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             overflow
);
  logic [WIDTH-1:0] b_op, add_r, sub_r, imm_zx, res, md_lo;
  logic add_ovf, sub_ovf, lt, ltu, ovf, md_op, md_done, acc;
  assign b_op = opcode == OP_RTYPE ? read_data_2 : imm_ext;
  assign imm_zx = {{(WIDTH-16){1'b0}}, imm_ext[15:0]};
  assign add_r = read_data_1 + b_op;
  assign sub_r = read_data_1 - read_data_2;
  assign add_ovf = (read_data_1[WIDTH-1] == b_op[WIDTH-1]) && (add_r[WIDTH-1] != read_data_1[WIDTH-1]);
  assign sub_ovf = (read_data_1[WIDTH-1] != read_data_2[WIDTH-1]) && (sub_r[WIDTH-1] != read_data_1[WIDTH-1]);
  assign lt = $signed(read_data_1) < $signed(b_op);
  assign ltu = read_data_1 < b_op;
  assign acc = in_valid & in_ready;
`ifdef ALU_MULDIV_EN
  logic [WIDTH-1:0] hi, lo;
  logic md_busy;
  muldiv_unit #(.WIDTH(WIDTH), .MD_CYCLES(MD_CYCLES)) u_md (
    .clk(clk), .rst(rst), .start(acc & md_op), .is_div(funct[1]), .is_signed(!funct[0]),
    .a(read_data_1), .b(read_data_2), .busy(md_busy), .done(md_done),
    .lo_next(md_lo), .hi(hi), .lo(lo)
  );
  assign in_ready = !md_busy;
`else
  assign in_ready = 1'b1;
  assign md_done = 1'b0;
  assign md_lo = '0;
`endif
  always_comb begin
    res = '0;
    ovf = 1'b0;
    md_op = 1'b0;
    case (opcode)
      OP_RTYPE: case (funct)
        F_ADD: begin res = add_r; ovf = add_ovf; end
        F_ADDU: res = add_r;
        F_SUB: begin res = sub_r; ovf = sub_ovf; end
        F_SUBU: res = sub_r;
        F_AND: res = read_data_1 & read_data_2;
        F_OR: res = read_data_1 | read_data_2;
        F_XOR: res = read_data_1 ^ read_data_2;
        F_NOR: res = ~(read_data_1 | read_data_2);
        F_SLT: res = {{(WIDTH-1){1'b0}}, lt};
        F_SLTU: res = {{(WIDTH-1){1'b0}}, ltu};
        F_SLL: res = read_data_2 << shamt;
        F_SRL: res = read_data_2 >> shamt;
        F_SRA: res = $signed(read_data_2) >>> shamt;
`ifdef ALU_MULDIV_EN
        F_MFHI: res = hi;
        F_MFLO: res = lo;
        F_MULT, F_MULTU, F_DIV, F_DIVU: md_op = 1'b1;
`endif
        default: ;
      endcase
      OP_ADDI: begin res = add_r; ovf = add_ovf; end
      OP_ADDIU, OP_LW, OP_SW: res = add_r;
      OP_SLTI: res = {{(WIDTH-1){1'b0}}, lt};
      OP_ANDI: res = read_data_1 & imm_zx;
      OP_ORI: res = read_data_1 | imm_zx;
      OP_LUI: res = {imm_ext[15:0], 16'b0};
      OP_BEQ, OP_BNE: res = sub_r;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_result <= '0;
      zero <= 1'b1;
      overflow <= 1'b0;
    end else begin
      out_valid <= (acc & !md_op) | md_done;
      if (acc && !md_op) begin
        alu_result <= res;
        zero <= res == '0;
        overflow <= ovf;
      end else if (md_done) begin
        alu_result <= md_lo;
        zero <= md_lo == '0;
        overflow <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_execute.sv
// tb_alu_execute: scoreboard bench for alu_execute; expectations follow ALU_MULDIV_EN
module tb_alu_execute;
  import mips_pkg::*;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  typedef struct {
    string tag;
    logic [31:0] res;
    logic ovf;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic [4:0] shamt = '0;
  logic [31:0] read_data_1 = '0;
  logic [31:0] read_data_2 = '0;
  logic [31:0] imm_ext = '0;
  logic out_valid, zero, overflow;
  logic [31:0] alu_result;
  exp_t sb[$];
  exp_t e;
  int n_tests = 0;
  int n_fail = 0;
  alu_execute #(.WIDTH(32), .MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .imm_ext(imm_ext),
    .out_valid(out_valid), .alu_result(alu_result), .zero(zero), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // push the expectation, then hold the instruction until the DUT takes it
  task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input string tag, input logic [31:0] res, input logic ovf, input bit push);
    logic took;
    int budget;
    if (push) sb.push_back('{tag, res, ovf});
    opcode = op; funct = fn; shamt = sh;
    read_data_1 = a; read_data_2 = b; imm_ext = imm;
    in_valid = 1'b1;
    took = 1'b0;
    budget = 200;
    while (!took && budget > 0) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      budget--;
    end
    chk({tag, "_accept"}, {31'b0, took}, 32'd1);
    #1 in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        chk({e.tag, "_res"}, alu_result, e.res);
        chk({e.tag, "_zero"}, {31'b0, zero}, {31'b0, e.res == 32'd0});
        chk({e.tag, "_ovf"}, {31'b0, overflow}, {31'b0, e.ovf});
      end
    end
  end
  initial begin
    int cnt;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd1);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    issue(OP_RTYPE, F_ADD, 0, 32'h7FFFFFFF, 32'd1, 0, "add_ovf", 32'h80000000, 1'b1, 1'b1);
    @(negedge clk);
    chk("add_lat_t1", {31'b0, out_valid}, 32'd1);
    @(negedge clk);
    chk("add_pulse_end", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    issue(OP_RTYPE, F_ADDU, 0, 32'h7FFFFFFF, 32'd1, 0, "addu", 32'h80000000, 1'b0, 1'b1);
    issue(OP_RTYPE, F_SUB, 0, 32'h80000000, 32'd1, 0, "sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b1);
    issue(OP_RTYPE, F_SUBU, 0, 32'h80000000, 32'd1, 0, "subu", 32'h7FFFFFFF, 1'b0, 1'b1);
    issue(OP_RTYPE, F_SLT, 0, 32'hFFFFFFFF, 32'd1, 0, "slt", 32'd1, 1'b0, 1'b1);
    issue(OP_RTYPE, F_SLTU, 0, 32'hFFFFFFFF, 32'd1, 0, "sltu", 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_SRA, 5'd4, 0, 32'h80000000, 0, "sra", 32'hF8000000, 1'b0, 1'b1);
    issue(OP_RTYPE, F_SRL, 5'd4, 0, 32'h80000000, 0, "srl", 32'h08000000, 1'b0, 1'b1);
    issue(OP_RTYPE, F_SLL, 5'd31, 0, 32'h3, 0, "sll", 32'h80000000, 1'b0, 1'b1);
    issue(OP_RTYPE, F_NOR, 0, 32'hF0F0F0F0, 32'h0F0F0F00, 0, "nor", 32'h0000000F, 1'b0, 1'b1);
    issue(OP_LUI, 0, 0, 32'hDEADBEEF, 0, 32'h00001234, "lui", 32'h12340000, 1'b0, 1'b1);
    issue(OP_ANDI, 0, 0, 32'hFFFFFFFF, 0, 32'hFFFF8001, "andi", 32'h00008001, 1'b0, 1'b1);
    issue(OP_ORI, 0, 0, 32'h00010000, 0, 32'hFFFF8000, "ori", 32'h00018000, 1'b0, 1'b1);
    issue(OP_ADDI, 0, 0, 32'h80000000, 0, 32'hFFFFFFFF, "addi_ovf", 32'h7FFFFFFF, 1'b1, 1'b1);
    issue(OP_SLTI, 0, 0, 32'hFFFFFFFE, 0, 32'hFFFFFFFF, "slti", 32'd1, 1'b0, 1'b1);
    issue(OP_LW, 0, 0, 32'h00001000, 0, 32'hFFFFFFFC, "lw_addr", 32'h00000FFC, 1'b0, 1'b1);
    issue(OP_BEQ, 0, 0, 32'h12345678, 32'h12345678, 0, "beq_eq", 32'd0, 1'b0, 1'b1);
    issue(OP_BNE, 0, 0, 32'd9, 32'd4, 0, "bne", 32'd5, 1'b0, 1'b1);
    issue(6'h3F, 0, 0, 32'd1, 32'd2, 32'd3, "bad_opcode", 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, 6'h3E, 0, 32'd1, 32'd2, 0, "bad_funct", 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      issue(OP_RTYPE, F_XOR, 0, a, b, 0, "rnd_xor", a ^ b, 1'b0, 1'b1);
      issue(OP_RTYPE, F_ADDU, 0, a, b, 0, "rnd_addu", a + b, 1'b0, 1'b1);
      issue(OP_RTYPE, F_SLTU, 0, a, b, 0, "rnd_sltu", {31'b0, a < b}, 1'b0, 1'b1);
    end
    issue(OP_RTYPE, F_MULT, 0, 32'hFFFFFFFD, 32'd7, 0, "mult", MD ? 32'hFFFFFFEB : 32'd0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
    end
    chk("mult_busy_cycles", cnt, MD ? 32'd32 : 32'd0);
    chk("mult_done_vld", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    issue(OP_RTYPE, F_MFHI, 0, 0, 0, 0, "mfhi_mult", MD ? 32'hFFFFFFFF : 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_MULTU, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "multu", MD ? 32'd1 : 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_MFHI, 0, 0, 0, 0, "mfhi_multu", MD ? 32'hFFFFFFFE : 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_DIV, 0, 32'hFFFFFFF9, 32'd2, 0, "div", MD ? 32'hFFFFFFFD : 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_MFHI, 0, 0, 0, 0, "mfhi_div", MD ? 32'hFFFFFFFF : 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_DIVU, 0, 32'd100, 32'd7, 0, "divu", MD ? 32'd14 : 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_MFHI, 0, 0, 0, 0, "mfhi_divu", MD ? 32'd2 : 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_DIVU, 0, 32'd5, 32'd0, 0, "divu_by0", MD ? 32'hFFFFFFFF : 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_MFHI, 0, 0, 0, 0, "mfhi_by0", MD ? 32'd5 : 32'd0, 1'b0, 1'b1);
    // held instruction must be consumed once, right after the engine finishes
    issue(OP_RTYPE, F_MULT, 0, 32'd3, 32'd4, 0, "mult_hold", MD ? 32'd12 : 32'd0, 1'b0, 1'b1);
    issue(OP_ADDI, 0, 0, 32'd5, 0, 32'd1, "addi_held", 32'd6, 1'b0, 1'b1);
    issue(OP_RTYPE, F_MFLO, 0, 0, 0, 0, "mflo_hold", MD ? 32'd12 : 32'd0, 1'b0, 1'b1);
    // abort: no result may ever appear for this MULTU when the engine exists
    issue(OP_RTYPE, F_MULTU, 0, 32'd1000, 32'd1000, 0, "multu_abort", 32'd0, 1'b0, !MD);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_no_vld", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    issue(OP_RTYPE, F_MFLO, 0, 0, 0, 0, "mflo_after_abort", 32'd0, 1'b0, 1'b1);
    issue(OP_RTYPE, F_MFHI, 0, 0, 0, 0, "mfhi_after_abort", 32'd0, 1'b0, 1'b1);
    repeat (60) @(negedge clk);
    chk("drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_execute.md
# alu_execute

Execute stage directly downstream of the register file: consumes the two read operands plus the decoded instruction fields and produces the ALU result, the zero flag and the signed-overflow flag. It also owns the HI/LO register pair and an iterative multiply/divide engine. While that engine runs, it back-pressures the stage upstream through a valid/ready handshake. The result feeds the memory/write-back path and the branch comparator.

## Interface
Parameters:
- `WIDTH`, 32: datapath width; only 32 is supported.
- `MD_CYCLES`, 32: multiply/divide iteration count; must equal `WIDTH`.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  instruction fields and operands are valid.
- `in_ready`  out  1  stage can accept; transfer occurs when `in_valid & in_ready`.
- `opcode`  in  6  instruction bits [31:26].
- `funct`  in  6  instruction bits [5:0] (R-type).
- `shamt`  in  5  instruction bits [10:6].
- `read_data_1`  in  32  rs operand.
- `read_data_2`  in  32  rt operand.
- `imm_ext`  in  32  sign-extended 16-bit immediate.
- `out_valid`  out  1  one-cycle pulse: the result outputs are valid.
- `alu_result`  out  32  registered result.
- `zero`  out  1  `alu_result == 0`, registered with the result.
- `overflow`  out  1  signed overflow for ADD/ADDI/SUB.

## Operation
- R-type (opcode 0x00), selected by `funct`:
  - ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
  - SLT 0x2A (signed), SLTU 0x2B (unsigned).
  - SLL 0x00, SRL 0x02, SRA 0x03, all shifting rt by `shamt`.
  - MFHI 0x10, MFLO 0x12.
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B.
- I-type, rs op imm:
  - ADDI 0x08 (flags overflow), ADDIU 0x09, SLTI 0x0A.
  - ANDI 0x0C and ORI 0x0D use the zero-extended `imm_ext[15:0]`.
  - LUI 0x0F gives `{imm[15:0],16'b0}`.
  - LW 0x23 and SW 0x2B give the address rs+imm.
  - BEQ 0x04 and BNE 0x05 give rs−rt; the consumer uses `zero`.
- Arithmetic wraps modulo 2^32. `overflow`=1 only for ADD/ADDI/SUB when the operands have equal sign (for SUB: opposite sign) and the result sign differs. `overflow`=0 for every other operation.
- Any unlisted opcode/funct: `out_valid` pulses with `alu_result`=0, `zero`=1, `overflow`=0.
- The FSM in the multiply/divide engine has three states: IDLE, MUL, DIV.
  - IDLE→MUL on an accepted MULT/MULTU; IDLE→DIV on an accepted DIV/DIVU.
  - MUL/DIV→IDLE after `MD_CYCLES` iterations.
- Multiply is shift-add on magnitudes, giving {HI,LO} = the 64-bit product. For signed MULT the product is negated when the operand signs differ.
- Divide is restoring division on magnitudes: LO = quotient, HI = remainder.
  - Signed quotient sign = sign(rs) XOR sign(rt).
  - Remainder sign = sign(rs).
- Divide by zero: runs the full iteration count, then LO=0xFFFFFFFF, HI=rs.
- MFHI/MFLO are accepted only in IDLE and return the current HI/LO.

## Timing
- Reset values:
  - `out_valid`=0, `alu_result`=0, `zero`=1, `overflow`=0.
  - HI=LO=0, state IDLE, `in_ready`=1.
- Single-cycle ops: accepted at edge T; `out_valid` and the results are visible from T+1 for exactly one cycle. Back-to-back acceptance every cycle is supported.
- MULT/DIV family:
  - `in_ready` drops in the cycle after acceptance and stays 0 for `MD_CYCLES` cycles.
  - HI/LO update and `out_valid` pulses at T+`MD_CYCLES`+1, with `alu_result`=new LO.
  - `in_ready` returns to 1 in that same cycle.
- `in_ready` is a function of state only; it never depends combinationally on `in_valid`.
- An instruction presented while `in_ready`=0 is not consumed. The source must hold its fields stable.
- `rst` asserted mid multiply/divide:
  - aborts the operation, returns to IDLE and clears HI/LO;
  - no `out_valid` is produced for the aborted operation.
- `rst` dominates a simultaneous `in_valid`.
- Outputs hold their last value when `out_valid`=0.

## Configuration
- `ALU_MULDIV_EN` defined: HI/LO, the engine, and MULT/MULTU/DIV/DIVU/MFHI/MFLO are implemented exactly as above.
- `ALU_MULDIV_EN` undefined:
  - the engine and HI/LO are removed and `in_ready` is tied to 1;
  - those six functs fall into the unlisted-opcode case (1-cycle latency, result 0).

## Structure
- Shared package `mips_pkg` holds the opcode and funct localparams and the engine state enum (IDLE/MUL/DIV).
- Sub-module `muldiv_unit` holds the iterative engine, HI/LO, and a start/done/busy interface. It is instantiated only under `ALU_MULDIV_EN`.
- `alu_execute` holds operand selection, the single-cycle datapath, the output registers and the handshake.

## Test plan
- ADD 0x7FFFFFFF+1 → `alu_result`=0x80000000, `overflow`=1, `out_valid` at T+1; ADDU with the same operands → `overflow`=0.
- SLT: −1 vs 1 → 1; SLTU: 0xFFFFFFFF vs 1 → 0; SRA 0x80000000 by 4 → 0xF8000000; LUI 0x1234 → 0x12340000.
- MULT −3×7 → `in_ready` low for 32 cycles, then `out_valid` with LO=0xFFFFFFEB and HI=0xFFFFFFFF; MFHI then returns 0xFFFFFFFF.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 5/0 → LO=0xFFFFFFFF, HI=5.
- `rst` pulsed at iteration 10 of MULTU → no `out_valid`; MFLO afterwards returns 0; `in_ready`=1 on the next cycle.
- BEQ with equal operands → `zero`=1; an instruction held while `in_ready`=0 is accepted exactly once after the engine completes.
